// File: rtl/tri_cos_collector.sv
// tri_cos_collector
//   Captures the 3-beat result burst of the triangle cosine engine. It finds the
//   largest angle, which is the one with the smallest cosine. It cross-checks the
//   engine's triangle type against that cosine. It then queues one record per
//   triangle in a small FIFO that feeds a valid/ready sink.
//   Optional feature: define TRI_COLLECT_STATS_EN to add the per-type counters
//   stat_acute / stat_right / stat_obtuse.
module tri_cos_collector #(
  parameter int COS_W      = 16,
  parameter int TOL        = 40,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [COS_W-1:0] in_cos,
  input  logic [1:0]       in_tri,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_tri,
  output logic [1:0]       out_big_idx,
  output logic [COS_W-1:0] out_min_cos,
  output logic             out_mismatch,
  output logic             frag_err,
  output logic [7:0]       drop_cnt
`ifdef TRI_COLLECT_STATS_EN
  ,
  output logic [15:0]      stat_acute,
  output logic [15:0]      stat_right,
  output logic [15:0]      stat_obtuse
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic signed [COS_W-1:0] TOL_POS = COS_W'(TOL);
  localparam logic signed [COS_W-1:0] TOL_NEG = -TOL_POS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_B1   = 2'd1,
    ST_B2   = 2'd2
  } cap_state_e;

  typedef enum logic [1:0] {
    TYPE_ACUTE  = 2'b00,
    TYPE_RIGHT  = 2'b01,
    TYPE_OBTUSE = 2'b10
  } tri_type_e;

  typedef struct packed {
    logic [1:0]       eng_tri;
    logic [1:0]       big_idx;
    logic [COS_W-1:0] min_cos;
    logic             mismatch;
  } rec_t;

  cap_state_e              state;
  logic signed [COS_W-1:0] cos0, cos1, cos2;
  logic [1:0]              eng_tri;
  logic                    done;

  // Capture FSM: gathers the three beats and pulses done after the last one.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cos0     <= '0;
      cos1     <= '0;
      cos2     <= '0;
      eng_tri  <= 2'b00;
      done     <= 1'b0;
      frag_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            cos0    <= $signed(in_cos);
            eng_tri <= in_tri;
            state   <= ST_B1;
          end
        end
        ST_B1: begin
          if (in_valid) begin
            cos1  <= $signed(in_cos);
            state <= ST_B2;
          end else begin
            frag_err <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        ST_B2: begin
          if (in_valid) begin
            cos2  <= $signed(in_cos);
            done  <= 1'b1;
            state <= ST_IDLE;
          end else begin
            frag_err <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic signed [COS_W-1:0] min_s;
  logic [1:0]              min_idx;
  tri_type_e               derived;
  rec_t                    new_rec;

  // Smallest cosine (ties keep the lowest index), the type it implies, and the record to write.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    min_s   = cos0;
    min_idx = 2'd0;
    if (cos1 < min_s) begin
      min_s   = cos1;
      min_idx = 2'd1;
    end
    if (cos2 < min_s) begin
      min_s   = cos2;
      min_idx = 2'd2;
    end
    if (min_s < TOL_NEG)
      derived = TYPE_OBTUSE;
    else if (min_s <= TOL_POS)
      derived = TYPE_RIGHT;
    else
      derived = TYPE_ACUTE;
    new_rec.eng_tri  = eng_tri;
    new_rec.big_idx  = min_idx;
    new_rec.min_cos  = min_s;
    new_rec.mismatch = (derived != eng_tri);
  end

  rec_t        mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, rd_en, wr_en, drop;
  rec_t        head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = out_valid & out_ready;
  // A full FIFO still accepts a write in the same cycle that its head is popped.
  assign wr_en = done & (~full | rd_en);
  assign drop  = done & full & ~rd_en;

  // Record FIFO: write/read pointers, storage and the saturating drop counter.
  // NOTE: the storage is tiny and drives the outputs directly, so it is reset to make them read 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= 8'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= new_rec;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign head         = mem[rd_ptr[AW-1:0]];
  assign out_valid    = ~empty;
  assign out_tri      = head.eng_tri;
  assign out_big_idx  = head.big_idx;
  assign out_min_cos  = head.min_cos;
  assign out_mismatch = head.mismatch;

`ifdef TRI_COLLECT_STATS_EN
  // Per-type counters of records actually written to the FIFO; they wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_acute  <= 16'd0;
      stat_right  <= 16'd0;
      stat_obtuse <= 16'd0;
    end else if (wr_en) begin
      case (derived)
        TYPE_ACUTE:  stat_acute  <= stat_acute + 16'd1;
        TYPE_RIGHT:  stat_right  <= stat_right + 16'd1;
        TYPE_OBTUSE: stat_obtuse <= stat_obtuse + 16'd1;
        default:     ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_tri_cos_collector.sv
// tb_tri_cos_collector
//   Table of directed bursts, hand-written multi-cycle sequences (fragment,
//   back-pressure with drop, reset mid-burst) and a randomized run against a
//   queue-based reference model.
module tb_tri_cos_collector;

  localparam int DEPTH = 2;
  localparam int TOLV  = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_cos = '0;
  logic [1:0]  in_tri = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_tri, out_big_idx;
  logic [15:0] out_min_cos;
  logic        out_mismatch, frag_err;
  logic [7:0]  drop_cnt;
`ifdef TRI_COLLECT_STATS_EN
  logic [15:0] stat_acute, stat_right, stat_obtuse;
`endif

  tri_cos_collector dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_cos(in_cos), .in_tri(in_tri),
    .out_valid(out_valid), .out_ready(out_ready), .out_tri(out_tri),
    .out_big_idx(out_big_idx), .out_min_cos(out_min_cos), .out_mismatch(out_mismatch),
    .frag_err(frag_err), .drop_cnt(drop_cnt)
`ifdef TRI_COLLECT_STATS_EN
    , .stat_acute(stat_acute), .stat_right(stat_right), .stat_obtuse(stat_obtuse)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int mn;
    int t;
    int mm;
  } exp_t;

  typedef struct {
    int   c0, c1, c2, t;
    exp_t e;
  } vec_t;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_rec(input string name, input exp_t e);
    check({name, " valid"},    int'(out_valid), 1);
    check({name, " tri"},      int'(out_tri), e.t);
    check({name, " big_idx"},  int'(out_big_idx), e.idx);
    check({name, " min_cos"},  int'($signed(out_min_cos)), e.mn);
    check({name, " mismatch"}, int'(out_mismatch), e.mm);
  endtask

  // Reference: smallest value first, then the first index holding it; type from |min|.
  function automatic exp_t ref_rec(input int c0, input int c1, input int c2, input int t);
    int   v[3];
    int   mn, d, der;
    exp_t e;
    v  = '{c0, c1, c2};
    mn = v[0];
    foreach (v[k]) if (v[k] < mn) mn = v[k];
    e.idx = 0;
    for (int k = 2; k >= 0; k--) if (v[k] == mn) e.idx = k;
    d   = (mn < 0) ? -mn : mn;
    der = (mn < -TOLV) ? 2 : ((d <= TOLV) ? 1 : 0);
    e.mn = mn;
    e.t  = t;
    e.mm = (der != t) ? 1 : 0;
    return e;
  endfunction

  function automatic int rand_cos();
    logic [15:0] r;
    if ($urandom_range(0, 1) == 0) return int'($urandom_range(0, 120)) - 60;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic beat(input int c, input int t);
    @(negedge clk);
    in_valid = 1'b1;
    in_cos   = 16'(c);
    in_tri   = 2'(t);
  endtask

  // Drives three beats and returns on the negedge just after beat 2 was sampled.
  task automatic burst(input int c0, input int c1, input int c2, input int t);
    beat(c0, t);
    beat(c1, int'($urandom_range(0, 3)));
    beat(c2, int'($urandom_range(0, 3)));
    @(negedge clk);
    in_valid = 1'b0;
    in_cos   = 16'($urandom);
  endtask

  vec_t vecs[10];
  exp_t ea, eb, ec;
  exp_t q[$];
  exp_t stage_rec;
  logic stage_valid;
  int   drop_model, bidx, cur_t, cyc_last;
  int   cv[3];

  initial begin
    vecs[0] = '{6554, 4915, 0, 1, '{2, 0, 1, 0}};
    vecs[1] = '{7168, 5632, -2048, 2, '{2, -2048, 2, 0}};
    vecs[2] = '{7168, 5632, -2048, 0, '{2, -2048, 0, 1}};
    vecs[3] = '{4096, 4096, 4096, 0, '{0, 4096, 0, 0}};
    vecs[4] = '{8000, 100, -40, 1, '{2, -40, 1, 0}};
    vecs[5] = '{8000, 100, -41, 1, '{2, -41, 1, 1}};
    vecs[6] = '{4096, 4096, 4096, 3, '{0, 4096, 3, 1}};
    vecs[7] = '{100, -5, -5, 1, '{1, -5, 1, 0}};
    vecs[8] = '{40, 300, 500, 1, '{0, 40, 1, 0}};
    vecs[9] = '{41, 300, 500, 1, '{0, 41, 1, 1}};

    // Reset state.
    do_reset();
    @(negedge clk);
    check("rst out_valid", int'(out_valid), 0);
    check("rst out_tri", int'(out_tri), 0);
    check("rst big_idx", int'(out_big_idx), 0);
    check("rst min_cos", int'(out_min_cos), 0);
    check("rst mismatch", int'(out_mismatch), 0);
    check("rst frag_err", int'(frag_err), 0);
    check("rst drop_cnt", int'(drop_cnt), 0);

    // Directed table: latency 2 cycles from beat 2, then record fields.
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      burst(vecs[i].c0, vecs[i].c1, vecs[i].c2, vecs[i].t);
      check($sformatf("vec%0d early valid", i), int'(out_valid), 0);
      @(negedge clk);
      check_rec($sformatf("vec%0d", i), vecs[i].e);
    end
    @(negedge clk);
    check("table drained", int'(out_valid), 0);

    // Fragment after beat 1, then a good burst.
    do_reset();
    beat(100, 0);
    beat(200, 0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("frag frag_err", int'(frag_err), 1);
    repeat (2) @(negedge clk);
    check("frag no record", int'(out_valid), 0);
    burst(6554, 4915, 0, 1);
    @(negedge clk);
    check_rec("after frag", ref_rec(6554, 4915, 0, 1));
    check("frag sticky", int'(frag_err), 1);

    // Back-pressure: three back-to-back bursts into a depth-2 FIFO.
    do_reset();
    out_ready = 1'b0;
    ea = ref_rec(6554, 4915, 0, 1);
    eb = ref_rec(7168, 5632, -2048, 2);
    ec = ref_rec(4096, 4096, 4096, 0);
    beat(6554, 1); beat(4915, 3); beat(0, 3);
    beat(7168, 2); beat(5632, 0); beat(-2048, 0);
    beat(4096, 0); beat(4096, 1); beat(4096, 2);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("bp drop_cnt", int'(drop_cnt), 1);
    check_rec("bp head A", ea);
    repeat (3) @(negedge clk);
    check_rec("bp hold A", ea);
    out_ready = 1'b1;
    @(negedge clk);
    check_rec("bp pop B", eb);
    @(negedge clk);
    check("bp empty", int'(out_valid), 0);
    check("bp drop kept", int'(drop_cnt), 1);

    // Reset asserted during beat 2 with a record queued and frag_err set.
    do_reset();
    out_ready = 1'b0;
    beat(100, 0);
    @(negedge clk);
    in_valid = 1'b0;
    burst(6554, 4915, 0, 1);
    beat(7168, 2);
    beat(5632, 2);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_cos = 16'(-2048);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check("mid rst out_valid", int'(out_valid), 0);
    check("mid rst out_tri", int'(out_tri), 0);
    check("mid rst min_cos", int'(out_min_cos), 0);
    check("mid rst frag_err", int'(frag_err), 0);
    out_ready = 1'b1;
    burst(7168, 5632, -2048, 2);
    @(negedge clk);
    check_rec("post rst rec", ref_rec(7168, 5632, -2048, 2));
    @(negedge clk);
    check("post rst single", int'(out_valid), 0);

    // Randomized run against the queue model (no fragments).
    do_reset();
    q.delete();
    stage_valid = 1'b0;
    drop_model  = 0;
    bidx        = 0;
    cur_t       = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      check("rnd valid", int'(out_valid), (q.size() > 0) ? 1 : 0);
      if (q.size() > 0) check_rec("rnd head", q[0]);
      if (cyc % 100 == 0) check("rnd drop_cnt", int'(drop_cnt), drop_model);
      out_ready = ($urandom_range(0, 3) != 0);
      cyc_last  = 0;
      if (bidx == 0) begin
        if ($urandom_range(0, 2) != 0) begin
          foreach (cv[k]) cv[k] = rand_cos();
          cur_t    = int'($urandom_range(0, 3));
          in_valid = 1'b1;
          in_cos   = 16'(cv[0]);
          in_tri   = 2'(cur_t);
          bidx     = 1;
        end else begin
          in_valid = 1'b0;
          in_cos   = 16'($urandom);
          in_tri   = 2'($urandom);
        end
      end else begin
        in_valid = 1'b1;
        in_cos   = 16'(cv[bidx]);
        in_tri   = 2'($urandom);
        if (bidx == 2) begin
          bidx     = 0;
          cyc_last = 1;
        end else begin
          bidx = bidx + 1;
        end
      end
      // Model the coming edge: pop first, then write or drop the staged record.
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (stage_valid) begin
        if (q.size() < DEPTH) q.push_back(stage_rec);
        else if (drop_model < 255) drop_model++;
      end
      stage_valid = (cyc_last != 0);
      if (cyc_last != 0) stage_rec = ref_rec(cv[0], cv[1], cv[2], cur_t);
    end
    @(negedge clk);
    check("rnd final drop_cnt", int'(drop_cnt), drop_model);
    check("rnd frag_err clear", int'(frag_err), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
